// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result checker: opcodes, checker states and
// the reference function that predicts the ALU result for a stimulus.
package alu_pkg;

  localparam int unsigned DATA_W         = 32;
  localparam int unsigned TIMEOUT_CYCLES = 64;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_NOTA = 3'b010,
    OP_NAND = 3'b011,
    OP_NOR  = 3'b100,
    OP_AND  = 3'b101,
    OP_OR   = 3'b110,
    OP_XOR  = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } chk_state_e;

  // Carry and borrow fall off the top: results are modulo 2^32.
  function automatic logic [DATA_W-1:0] alu_expect(input alu_op_e         op,
                                                   input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] r;
    r = '0;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_NOTA: r = ~a;
      OP_NAND: r = ~(a & b);
      OP_NOR:  r = ~(a | b);
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_chk_fifo.sv
// Expected-result FIFO for the ALU checker. Power-of-two depth, registered
// occupancy, synchronous flush; pushes when full and pops when empty are dropped.
module alu_chk_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      cnt_q;
  logic             push_en, pop_en;

  assign full    = (cnt_q == FULL_CNT);
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign rdata   = mem_q[rptr_q];
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;

  // NOTE: storage has no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push_en) mem_q[wptr_q] <= wdata;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (flush) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_en) wptr_q <= wptr_q + 1'b1;
      if (pop_en)  rptr_q <= rptr_q + 1'b1;
      case ({push_en, pop_en})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/alu_checker.sv
// ALU result checker: predicts results for accepted stimuli, queues them and
// tallies DUT results. Optional DRAIN timeout enabled by macro ALU_CHK_TIMEOUT_EN.
module alu_checker
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              stim_valid,
  input  logic [31:0]       stim_a,
  input  logic [31:0]       stim_b,
  input  logic [2:0]        stim_op,
  output logic              stim_ready,
  input  logic              res_valid,
  input  logic [31:0]       res_r,
  output logic [CNT_W-1:0]  pass_cnt,
  output logic [CNT_W-1:0]  fail_cnt,
  output logic [31:0]       fail_exp,
  output logic [31:0]       fail_got,
  output logic              underflow,
  output logic              timeout,
  output logic              busy,
  output logic              done
);

  localparam int               AW      = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  chk_state_e        state_q, state_d;
  logic [CNT_W-1:0]  pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0]  fail_cnt_q, fail_cnt_d;
  logic [31:0]       fail_exp_q, fail_exp_d;
  logic [31:0]       fail_got_q, fail_got_d;
  logic              underflow_q, underflow_d;

  logic              fifo_full, fifo_empty, fifo_flush;
  logic [31:0]       fifo_rdata;
  logic [AW:0]       fifo_count;
  logic              active, launch, push, pop, miss, drained, tmo_expire;

  assign active     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign launch     = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign stim_ready = (state_q == ST_RUN) && !fifo_full;
  assign push       = stim_valid && stim_ready;
  assign pop        = res_valid && active && !fifo_empty;
  assign miss       = res_valid && active && fifo_empty;
  assign fifo_flush = launch;
  // No pushes happen in DRAIN, so a pop of the last entry leaves the FIFO empty.
  assign drained    = fifo_empty || (pop && (fifo_count == (AW + 1)'(1)));

  alu_chk_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (fifo_flush),
    .push  (push),
    .wdata (alu_expect(alu_op_e'(stim_op), stim_a, stim_b)),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

`ifdef ALU_CHK_TIMEOUT_EN
  logic [5:0] tmo_q;
  logic       timeout_q;

  assign tmo_expire = (state_q == ST_DRAIN) && !drained && (tmo_q == 6'(TIMEOUT_CYCLES - 1));
  assign timeout    = timeout_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      tmo_q <= ((state_q == ST_DRAIN) && !drained) ? tmo_q + 1'b1 : '0;
      if (launch)          timeout_q <= 1'b0;
      else if (tmo_expire) timeout_q <= 1'b1;
    end
  end
`else
  assign tmo_expire = 1'b0;
  assign timeout    = 1'b0;
`endif

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    state_d     = state_q;
    pass_cnt_d  = pass_cnt_q;
    fail_cnt_d  = fail_cnt_q;
    fail_exp_d  = fail_exp_q;
    fail_got_d  = fail_got_q;
    underflow_d = underflow_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d     = ST_RUN;
          pass_cnt_d  = '0;
          fail_cnt_d  = '0;
          fail_exp_d  = '0;
          fail_got_d  = '0;
          underflow_d = 1'b0;
        end
      end
      ST_RUN: begin
        if (stop) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (drained || tmo_expire) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (pop) begin
      if (fifo_rdata == res_r) begin
        if (pass_cnt_q != CNT_MAX) pass_cnt_d = pass_cnt_q + 1'b1;
      end else begin
        if (fail_cnt_q == '0) begin
          fail_exp_d = fifo_rdata;
          fail_got_d = res_r;
        end
        if (fail_cnt_q != CNT_MAX) fail_cnt_d = fail_cnt_q + 1'b1;
      end
    end
    if (miss) underflow_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pass_cnt_q  <= '0;
      fail_cnt_q  <= '0;
      fail_exp_q  <= '0;
      fail_got_q  <= '0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pass_cnt_q  <= pass_cnt_d;
      fail_cnt_q  <= fail_cnt_d;
      fail_exp_q  <= fail_exp_d;
      fail_got_q  <= fail_got_d;
      underflow_q <= underflow_d;
    end
  end

  assign pass_cnt  = pass_cnt_q;
  assign fail_cnt  = fail_cnt_q;
  assign fail_exp  = fail_exp_q;
  assign fail_got  = fail_got_q;
  assign underflow = underflow_q;
  assign busy      = active;
  assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_alu_checker.sv
// Bench for alu_checker: directed literal scenarios plus random traffic,
// all outputs compared every cycle against a queue-based reference model.
module tb_alu_checker;

  localparam int DEPTH    = 4;
  localparam int TB_CNT_W = 5;
  localparam int CMAX     = (1 << TB_CNT_W) - 1;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                start = 1'b0, stop = 1'b0, stim_valid = 1'b0, res_valid = 1'b0;
  logic [31:0]         stim_a = '0, stim_b = '0, res_r = '0;
  logic [2:0]          stim_op = '0;
  logic                stim_ready, underflow, timeout, busy, done;
  logic [TB_CNT_W-1:0] pass_cnt, fail_cnt;
  logic [31:0]         fail_exp, fail_got;

  int n_checks = 0;
  int n_pass   = 0;

  alu_checker #(.DEPTH(DEPTH), .CNT_W(TB_CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .stim_valid(stim_valid), .stim_a(stim_a), .stim_b(stim_b), .stim_op(stim_op),
    .stim_ready(stim_ready), .res_valid(res_valid), .res_r(res_r),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .fail_exp(fail_exp), .fail_got(fail_got),
    .underflow(underflow), .timeout(timeout), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
  endtask

  // ---------------- reference model ----------------
  typedef enum {M_IDLE, M_RUN, M_DRAIN, M_DONE} mode_t;
  mode_t       m_mode = M_IDLE;
  logic [31:0] m_q[$];
  int          m_pass = 0, m_fail = 0, m_drain = 0;
  logic [31:0] m_exp = '0, m_got = '0;
  bit          m_uf = 0, m_to = 0;

  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return ~a;
      3'd3:    return ~(a & b);
      3'd4:    return ~(a | b);
      3'd5:    return a & b;
      3'd6:    return a | b;
      default: return a ^ b;
    endcase
  endfunction

  task automatic model_clear();
    m_q.delete();
    m_pass = 0; m_fail = 0; m_exp = '0; m_got = '0; m_uf = 0; m_to = 0; m_drain = 0;
  endtask

  task automatic model_step();
    bit          take;
    logic [31:0] e;
    take = stim_valid && (m_mode == M_RUN) && (m_q.size() < DEPTH);
    if ((m_mode == M_IDLE || m_mode == M_DONE) && start) begin
      model_clear();
      m_mode = M_RUN;
    end else if (m_mode == M_RUN || m_mode == M_DRAIN) begin
      if (res_valid) begin
        if (m_q.size() == 0) m_uf = 1;
        else begin
          e = m_q.pop_front();
          if (e == res_r) m_pass = (m_pass < CMAX) ? m_pass + 1 : CMAX;
          else begin
            if (m_fail == 0) begin m_exp = e; m_got = res_r; end
            m_fail = (m_fail < CMAX) ? m_fail + 1 : CMAX;
          end
        end
      end
      if (take) m_q.push_back(ref_alu(stim_op, stim_a, stim_b));
      if (m_mode == M_RUN) begin
        if (stop) begin m_mode = M_DRAIN; m_drain = 0; end
      end else if (m_q.size() == 0) m_mode = M_DONE;
`ifdef ALU_CHK_TIMEOUT_EN
      else begin
        m_drain++;
        if (m_drain == 64) begin m_mode = M_DONE; m_to = 1; end
      end
`endif
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin model_clear(); m_mode = M_IDLE; end
    else model_step();
  end

  // Cycle-by-cycle comparison of every output against the model.
  initial forever begin
    @(posedge clk);
    #1;
    check("cyc stim_ready", stim_ready, (m_mode == M_RUN) && (m_q.size() < DEPTH));
    check("cyc busy",       busy,       (m_mode == M_RUN) || (m_mode == M_DRAIN));
    check("cyc done",       done,       m_mode == M_DONE);
    check("cyc pass_cnt",   pass_cnt,   m_pass);
    check("cyc fail_cnt",   fail_cnt,   m_fail);
    check("cyc fail_exp",   fail_exp,   m_exp);
    check("cyc fail_got",   fail_got,   m_got);
    check("cyc underflow",  underflow,  m_uf);
    check("cyc timeout",    timeout,    m_to);
  end

  // ---------------- stimulus helpers ----------------
  task automatic pulse_start();
    start = 1'b1; @(negedge clk); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; @(negedge clk); stop = 1'b0;
  endtask

  task automatic push(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    stim_valid = 1'b1; stim_op = op; stim_a = a; stim_b = b;
    @(negedge clk);
    stim_valid = 1'b0;
  endtask

  task automatic result(input logic [31:0] r);
    res_valid = 1'b1; res_r = r;
    @(negedge clk);
    res_valid = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset stim_ready", stim_ready, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset pass_cnt", pass_cnt, 0);
    rst = 1'b0;

    // Basic add pass, subtract wrap, xor mismatch capture.
    pulse_start();
    push(3'b000, 32'd5, 32'd3);
    result(32'd8);
    check("add pass_cnt", pass_cnt, 1);
    check("add fail_cnt", fail_cnt, 0);
    push(3'b001, 32'd0, 32'd1);
    result(32'hFFFF_FFFF);
    check("sub wrap pass_cnt", pass_cnt, 2);
    push(3'b111, 32'hF0, 32'h0F);
    result(32'h00);
    check("xor fail_cnt", fail_cnt, 1);
    check("xor fail_exp", fail_exp, 32'hFF);
    check("xor fail_got", fail_got, 32'h00);

    // Result with nothing queued.
    result(32'h123);
    check("underflow flag", underflow, 1);
    check("underflow pass_cnt", pass_cnt, 2);
    check("underflow fail_cnt", fail_cnt, 1);

    // Fill the FIFO, then simultaneous push and pop at occupancy 3.
    for (int i = 1; i <= 4; i++) push(3'b000, 32'(i), 32'd1);
    check("full stim_ready", stim_ready, 0);
    result(32'd2);
    check("three held stim_ready", stim_ready, 1);
    stim_valid = 1'b1; stim_op = 3'b000; stim_a = 32'd10; stim_b = 32'd1;
    res_valid = 1'b1; res_r = 32'd3;
    @(negedge clk);
    stim_valid = 1'b0; res_valid = 1'b0;
    check("push+pop stim_ready", stim_ready, 1);
    push(3'b000, 32'd20, 32'd1);
    check("refill stim_ready", stim_ready, 0);
    result(32'd4);
    result(32'd5);

    // Stop with two pending, drain them.
    pulse_stop();
    check("drain busy", busy, 1);
    check("drain stim_ready", stim_ready, 0);
    result(32'd11);
    check("drain one left done", done, 0);
    result(32'd21);
    check("drained done", done, 1);
    check("drained busy", busy, 0);
    check("drained pass_cnt", pass_cnt, 8);

    // Restart from DONE clears the run; stop with results withheld.
    pulse_start();
    check("restart pass_cnt", pass_cnt, 0);
    check("restart fail_exp", fail_exp, 0);
    check("restart underflow", underflow, 0);
    push(3'b101, 32'hFF, 32'h0F);
    push(3'b010, 32'h0, 32'h0);
    pulse_stop();
`ifdef ALU_CHK_TIMEOUT_EN
    repeat (63) @(negedge clk);
    check("tmo cycle64 busy", busy, 1);
    @(negedge clk);
    check("tmo done", done, 1);
    check("tmo flag", timeout, 1);
`else
    repeat (100) @(negedge clk);
    check("no tmo busy", busy, 1);
    check("no tmo flag", timeout, 0);
    result(32'h0F);
    result(32'hFFFF_FFFF);
    check("late drain done", done, 1);
    check("late drain pass_cnt", pass_cnt, 2);
`endif

    // Reset mid-run with three pending.
    pulse_start();
    push(3'b000, 32'd1, 32'd1);
    push(3'b000, 32'd2, 32'd2);
    result(32'd2);
    push(3'b000, 32'd3, 32'd3);
    push(3'b000, 32'd4, 32'd4);
    check("pre-reset pass_cnt", pass_cnt, 1);
    rst = 1'b1;
    #1;
    check("async rst busy", busy, 0);
    check("async rst stim_ready", stim_ready, 0);
    check("async rst pass_cnt", pass_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    check("start+stop runs", stim_ready, 1);
    push(3'b000, 32'd7, 32'd8);
    result(32'd15);
    check("post-reset pass_cnt", pass_cnt, 1);
    check("post-reset underflow", underflow, 0);

    // Random traffic; results mostly track the model's queue head.
    for (int i = 0; i < 3000; i++) begin
      rst        = ($urandom_range(0, 599) == 0);
      start      = ($urandom_range(0, 29) == 0);
      stop       = ($urandom_range(0, 29) == 0);
      stim_valid = 1'($urandom_range(0, 1));
      stim_op    = 3'($urandom);
      stim_a     = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : 32'($urandom);
      stim_b     = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : 32'($urandom);
      res_valid  = ($urandom_range(0, 9) < 4);
      if (m_q.size() > 0 && $urandom_range(0, 9) < 8) res_r = m_q[0];
      else res_r = 32'($urandom);
      @(negedge clk);
    end
    rst = 1'b0; start = 1'b0; stop = 1'b0; stim_valid = 1'b0; res_valid = 1'b0;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_checker.md
ALU_CHECKER -- requirements
Module: alu_checker

Interface
REQ-001 SHALL have parameter DEPTH, default 4, expected-result FIFO depth (power of two, 2..16).
REQ-002 SHALL have parameter CNT_W, default 16, width of pass/fail counters.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  one-cycle pulse, begins or restarts a checking run.
REQ-006 SHALL have port stop  input  1  one-cycle pulse, ends stimulus acceptance.
REQ-007 SHALL have port stim_valid  input  1  stimulus transaction present.
REQ-008 SHALL have ports stim_a and stim_b  input  32 each  operands.
REQ-009 SHALL have port stim_op  input  3  opcode.
REQ-010 SHALL have port stim_ready  output  1  FIFO not full and state RUN.
REQ-011 SHALL have port res_valid  input  1  DUT result present.
REQ-012 SHALL have port res_r  input  32  DUT result.
REQ-013 SHALL have ports pass_cnt and fail_cnt  output  CNT_W each  compare tallies.
REQ-014 SHALL have ports fail_exp and fail_got  output  32 each  first mismatch capture.
REQ-015 SHALL have ports underflow, timeout, busy, done  output  1 each  status flags.

Function
REQ-016 SHALL compute expected on stimulus accept: 000 a+b, 001 a-b, 010 ~a, 011 ~(a&b), 100 ~(a|b), 101 a&b, 110 a|b, 111 a^b; arithmetic modulo 2^32, carry/borrow dropped.
REQ-017 SHALL push expected into FIFO when stim_valid && stim_ready; push visible to compare no earlier than next cycle.
REQ-018 SHALL pop FIFO head and compare with res_r when res_valid in RUN or DRAIN and FIFO not empty; equal increments pass_cnt, else fail_cnt.
REQ-019 SHALL keep FIFO occupancy unchanged on simultaneous push and pop; stim_ready = !full (no pop lookahead).
REQ-020 SHALL on res_valid with empty FIFO set underflow sticky, discard result, leave counters unchanged.
REQ-021 SHALL saturate pass_cnt and fail_cnt at 2^CNT_W-1.
REQ-022 SHALL load fail_exp/fail_got on first mismatch of a run only; later mismatches do not overwrite.
REQ-023 SHALL implement states IDLE, RUN, DRAIN, DONE.
REQ-024 SHALL transition IDLE->RUN or DONE->RUN on start, clearing counters, captures, underflow, timeout and FIFO in that edge.
REQ-025 SHALL transition RUN->DRAIN on stop; stop in other states ignored; start in RUN/DRAIN ignored.
REQ-026 SHALL transition DRAIN->DONE when FIFO empty (including pop emptying it that cycle -> DONE next cycle).
REQ-027 SHALL drive busy=1 in RUN/DRAIN, done=1 in DONE only; ignore res_valid in IDLE and DONE.
REQ-028 SHALL accept start and stop same cycle in IDLE as start only.

Reset
REQ-029 SHALL on rst asynchronously enter IDLE, empty FIFO, zero all outputs (stim_ready=0, busy=0, done=0, counters 0, captures 0, flags 0).
REQ-030 SHALL on rst mid-run discard all pending expected values; no compare occurs in the reset-release cycle.

Configuration
REQ-031 SHALL with macro ALU_CHK_TIMEOUT_EN defined count cycles in DRAIN, and after 64 consecutive DRAIN cycles with FIFO non-empty enter DONE and set timeout sticky.
REQ-032 SHALL without ALU_CHK_TIMEOUT_EN tie timeout to 0 and remain in DRAIN until FIFO empty.

Structure
REQ-033 SHALL take opcode constants, state enum and expected-value function from shared package alu_pkg.
REQ-034 SHALL place the expected FIFO in sub-module alu_chk_fifo (DEPTH, 32-bit data, push/pop/full/empty).

Verification
REQ-035 SHALL cover: start; push a=5,b=3 op=000; res_r=8 -> pass_cnt=1, fail_cnt=0.
REQ-036 SHALL cover: op=001 a=0 b=1, res_r=32'hFFFFFFFF -> pass; then op=111 a=F0 b=0F res_r=00 -> fail_cnt=1, fail_exp=FF, fail_got=00.
REQ-037 SHALL cover: push 4 without results -> stim_ready=0 on cycle after 4th push; push+pop same cycle when 3 held -> occupancy stays 3.
REQ-038 SHALL cover: res_valid with empty FIFO in RUN -> underflow=1, counters unchanged.
REQ-039 SHALL cover: stop with 2 pending, two results -> done=1 cycle after second pop; with ALU_CHK_TIMEOUT_EN and no results -> done and timeout after 64 DRAIN cycles.
REQ-040 SHALL cover: rst asserted mid-RUN with 3 pending -> immediate IDLE, all outputs 0; subsequent start, one push/result -> pass_cnt=1.
